// File: rtl/meriac_tt02_morse_decode.sv
// Morse receiver: samples a key level, classifies marks as dots/dashes and emits one ASCII strobe per letter, plus a space on word gaps.
// Optional feature macro: MORSE_DECODE_ERR_EN (unknown or overflowed letters emit '?' with an err pulse).
module meriac_tt02_morse_decode #(
  parameter int UNIT_CYCLES = 898
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [6:0] char,
  output logic       char_valid,
  output logic       busy,
  output logic       err
);

  localparam int               PRE_W     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(UNIT_CYCLES - 1);
  localparam logic [6:0]       SYM_EMPTY = 7'b000_0001;

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP} state_t;

  typedef struct packed {
    logic       known;
    logic [6:0] ascii;
  } lookup_t;

  // Symbol register layout: a leading 1 sentinel followed by the symbols, first symbol
  // nearest the sentinel, 0 = dot, 1 = dash.
  function automatic lookup_t lookup(input logic [6:0] code);
    lookup_t r;
    r.known = 1'b1;
    r.ascii = 7'h3F;
    case (code)
      7'b1_01:     r.ascii = 7'h41;
      7'b1_1000:   r.ascii = 7'h42;
      7'b1_1010:   r.ascii = 7'h43;
      7'b1_100:    r.ascii = 7'h44;
      7'b1_0:      r.ascii = 7'h45;
      7'b1_0010:   r.ascii = 7'h46;
      7'b1_110:    r.ascii = 7'h47;
      7'b1_0000:   r.ascii = 7'h48;
      7'b1_00:     r.ascii = 7'h49;
      7'b1_0111:   r.ascii = 7'h4A;
      7'b1_101:    r.ascii = 7'h4B;
      7'b1_0100:   r.ascii = 7'h4C;
      7'b1_11:     r.ascii = 7'h4D;
      7'b1_10:     r.ascii = 7'h4E;
      7'b1_111:    r.ascii = 7'h4F;
      7'b1_0110:   r.ascii = 7'h50;
      7'b1_1101:   r.ascii = 7'h51;
      7'b1_010:    r.ascii = 7'h52;
      7'b1_000:    r.ascii = 7'h53;
      7'b1_1:      r.ascii = 7'h54;
      7'b1_001:    r.ascii = 7'h55;
      7'b1_0001:   r.ascii = 7'h56;
      7'b1_011:    r.ascii = 7'h57;
      7'b1_1001:   r.ascii = 7'h58;
      7'b1_1011:   r.ascii = 7'h59;
      7'b1_1100:   r.ascii = 7'h5A;
      7'b1_11111:  r.ascii = 7'h30;
      7'b1_01111:  r.ascii = 7'h31;
      7'b1_00111:  r.ascii = 7'h32;
      7'b1_00011:  r.ascii = 7'h33;
      7'b1_00001:  r.ascii = 7'h34;
      7'b1_00000:  r.ascii = 7'h35;
      7'b1_10000:  r.ascii = 7'h36;
      7'b1_11000:  r.ascii = 7'h37;
      7'b1_11100:  r.ascii = 7'h38;
      7'b1_11110:  r.ascii = 7'h39;
      default:     r.known = 1'b0;
    endcase
    return r;
  endfunction

  logic             key_s1_q, key_s2_q, key_prev_q;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [2:0]       units_q, units_d;
  logic [6:0]       sym_q, sym_d;
  logic             ovf_q, ovf_d;
  logic             word_q, word_d;
  state_t           state_q, state_d;
  logic [6:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic    rise, fall, wrap, letter_trig, word_trig;
  lookup_t lk;

  assign rise = key_s2_q & ~key_prev_q;
  assign fall = ~key_s2_q & key_prev_q;
  assign wrap = (presc_q == PRE_LAST);

  // Triggers key off the unit-count increment, not its next value, so a key edge landing on
  // the same cycle (which clears the counters) cannot swallow an emission.
  assign letter_trig = (state_q == S_GAP) && wrap && (units_q == 3'd2) && (sym_q != SYM_EMPTY);
  assign word_trig   = (state_q == S_GAP) && wrap && (units_q == 3'd6) && word_q;
  assign lk          = lookup(sym_q);

  always_comb begin : timer
    presc_d = presc_q + 1'b1;
    units_d = units_q;
    if (rise || fall) begin
      presc_d = '0;
      units_d = '0;
    end else if (wrap) begin
      presc_d = '0;
      if (units_q != 3'd7) units_d = units_q + 3'd1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin : fsm_next
    state_d = state_q;
    sym_d   = sym_q;
    ovf_d   = ovf_q;
    word_d  = word_q;
    char_d  = char_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_MARK;
      end
      S_MARK: begin
        if (fall) begin
          if (sym_q[6]) ovf_d = 1'b1;
          else          sym_d = {sym_q[5:0], (units_q >= 3'd2)};
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (letter_trig) begin
          if (lk.known && !ovf_q) begin
            char_d  = lk.ascii;
            valid_d = 1'b1;
          end
`ifdef MORSE_DECODE_ERR_EN
          else begin
            char_d  = 7'h3F;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end
`endif
          sym_d  = SYM_EMPTY;
          ovf_d  = 1'b0;
          word_d = 1'b1;
        end
        if (word_trig) begin
          char_d  = 7'h20;
          valid_d = 1'b1;
          word_d  = 1'b0;
        end
        if (rise)                            state_d = S_MARK;
        else if (wrap && units_q == 3'd6)    state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      key_prev_q <= 1'b0;
      presc_q    <= '0;
      units_q    <= '0;
      sym_q      <= SYM_EMPTY;
      ovf_q      <= 1'b0;
      word_q     <= 1'b0;
      state_q    <= S_IDLE;
      char_q     <= 7'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      presc_q    <= presc_d;
      units_q    <= units_d;
      sym_q      <= sym_d;
      ovf_q      <= ovf_d;
      word_q     <= word_d;
      state_q    <= state_d;
      char_q     <= char_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign char       = char_q;
  assign char_valid = valid_q;
  assign err        = err_q;
  assign busy       = (sym_q != SYM_EMPTY);

endmodule

// File: tb/tb_meriac_tt02_morse_decode.sv
// Bench for meriac_tt02_morse_decode: timing/string reference model compared every cycle, plus directed literal checks.
module tb_meriac_tt02_morse_decode;

  localparam int U = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic [6:0] char;
  logic       char_valid, busy, err;

  meriac_tt02_morse_decode #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .char       (char),
    .char_valid (char_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_chg = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  string codes[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  typedef enum {P_IDLE, P_MARK, P_GAP} phase_t;

  phase_t     ph = P_IDLE;
  logic       k1 = 0, k2 = 0, k3 = 0;   // key as sampled 1, 2 and 3 edges ago
  int         t = 0;                    // cycles since the last key edge was acted on
  string      letter = "";
  bit         ovf = 0, wp = 0;
  logic [6:0] e_char = 0;
  logic       e_valid = 0, e_err = 0;
  logic       m_rise, m_fall;
  int         m_nt;

  function automatic int find_code(input string s);
    for (int i = 0; i < 36; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic emit_letter();
    int i;
    i = find_code(letter);
    if (i >= 0 && !ovf) begin
      e_char  = (i < 26) ? 7'(65 + i) : 7'(48 + i - 26);
      e_valid = 1;
    end else begin
`ifdef MORSE_DECODE_ERR_EN
      e_char  = 7'h3F;
      e_valid = 1;
      e_err   = 1;
`endif
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      k1 = 0; k2 = 0; k3 = 0; t = 0; letter = ""; ovf = 0; wp = 0; ph = P_IDLE;
      e_char = 0; e_valid = 0; e_err = 0;
    end else begin
      m_rise  = k2 && !k3;
      m_fall  = !k2 && k3;
      m_nt    = (t < 8 * U) ? t + 1 : t;
      e_valid = 0;
      e_err   = 0;
      case (ph)
        P_IDLE: if (m_rise) ph = P_MARK;
        P_MARK: if (m_fall) begin
          if (letter.len() == 6) ovf = 1;
          else if (t >= 2 * U)   letter = {letter, "-"};
          else                   letter = {letter, "."};
          ph = P_GAP;
        end
        P_GAP: begin
          if (m_nt == 3 * U && letter.len() != 0) begin
            emit_letter();
            letter = ""; ovf = 0; wp = 1;
          end
          if (m_nt == 7 * U && wp) begin
            e_char = 7'h20; e_valid = 1; wp = 0;
          end
          if (m_rise)              ph = P_MARK;
          else if (m_nt == 7 * U)  ph = P_IDLE;
        end
        default: ph = P_IDLE;
      endcase
      t  = (m_rise || m_fall) ? 0 : m_nt;
      k3 = k2; k2 = k1; k1 = key;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("char", char, e_char);
      check("char_valid", char_valid, e_valid);
      check("busy", busy, letter.len() != 0);
      check("err", err, e_err);
    end
  end

  // ---------------- emission log for directed checks ----------------
  logic [6:0] lc[$];
  int         lt[$];
  logic       lb[$], le[$];

  always @(negedge clk) begin
    if (char_valid === 1'b1) begin
      lc.push_back(char); lt.push_back(cyc); lb.push_back(busy); le.push_back(err);
    end
  end

  function automatic logic [6:0] lc_at(input int i);
    return (i < lc.size()) ? lc[i] : 7'bx;
  endfunction
  function automatic int lt_at(input int i);
    return (i < lt.size()) ? lt[i] : -1000;
  endfunction
  function automatic logic lb_at(input int i);
    return (i < lb.size()) ? lb[i] : 1'bx;
  endfunction
  function automatic logic le_at(input int i);
    return (i < le.size()) ? le[i] : 1'bx;
  endfunction

  task automatic clear_log();
    lc.delete(); lt.delete(); lb.delete(); le.delete();
  endtask

  // All stimulus tasks are entered and left on a negative edge.
  task automatic seg(input logic v, input int n);
    key = v;
    last_chg = cyc;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input string code, input int gap);
    for (int i = 0; i < code.len(); i++) begin
      seg(1'b1, (code[i] == "-") ? 3 * U : U);
      seg(1'b0, (i == code.len() - 1) ? gap : U);
    end
  endtask

  int f;

  initial begin
    rst = 1; key = 0;
    repeat (3) @(negedge clk);
    check("rst_char", char, 7'h00);
    check("rst_valid", char_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    chk_en = 1;
    rst = 0;
    repeat (5) @(negedge clk);

    // E: emission 3U+3 after the raw fall, space at 7U+3
    clear_log();
    send(".", 8 * U);
    f = last_chg;
    check("E_count", lc.size(), 2);
    check("E_char", lc_at(0), 7'h45);
    check("E_latency", lt_at(0) - f, 3 * U + 3);
    check("E_space", lc_at(1), 7'h20);
    check("E_space_latency", lt_at(1) - f, 7 * U + 3);

    // A with busy tracking
    clear_log();
    seg(1'b1, U);
    seg(1'b0, 5);
    check("A_busy_after_dot", busy, 1'b1);
    seg(1'b0, U - 5);
    seg(1'b1, 3 * U);
    seg(1'b0, 5);
    check("A_busy_after_dash", busy, 1'b1);
    seg(1'b0, 8 * U - 5);
    check("A_count", lc.size(), 2);
    check("A_char", lc_at(0), 7'h41);
    check("A_busy_at_emit", lb_at(0), 1'b0);
    check("A_space", lc_at(1), 7'h20);

    // SOS with letter gaps comfortably past 3 units
    clear_log();
    send("...", 35);
    send("---", 35);
    send("...", 8 * U);
    check("SOS_count", lc.size(), 4);
    check("SOS_0", lc_at(0), 7'h53);
    check("SOS_1", lc_at(1), 7'h4F);
    check("SOS_2", lc_at(2), 7'h53);
    check("SOS_space", lc_at(3), 7'h20);

    // eight dots overflow the six-symbol register
    clear_log();
    send("........", 8 * U);
`ifdef MORSE_DECODE_ERR_EN
    check("ovf_count", lc.size(), 2);
    check("ovf_char", lc_at(0), 7'h3F);
    check("ovf_err", le_at(0), 1'b1);
    check("ovf_space", lc_at(1), 7'h20);
`else
    check("ovf_count", lc.size(), 1);
    check("ovf_space_only", lc_at(0), 7'h20);
`endif
    check("ovf_busy_end", busy, 1'b0);

    // rise lands exactly on the letter-gap trigger after "T"
    clear_log();
    send("-", 3 * U);
    send("-", 8 * U);
    check("TT_count", lc.size(), 3);
    check("TT_0", lc_at(0), 7'h54);
    check("TT_1", lc_at(1), 7'h54);
    check("TT_space", lc_at(2), 7'h20);

    // reset mid-dash with a dot already pending: partial letter discarded
    clear_log();
    send(".", U);
    seg(1'b1, 15);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_valid", char_valid, 1'b0);
    seg(1'b1, 45);
    seg(1'b0, 8 * U);
    check("rstmid_count", lc.size(), 2);
    check("rstmid_char", lc_at(0), 7'h54);
    check("rstmid_space", lc_at(1), 7'h20);

    // randomized key traffic against the model
    for (int n = 0; n < 250; n++) begin
      int r;
      seg(1'b1, $urandom_range(1, 45));
      r = $urandom_range(0, 9);
      if (r < 5)      seg(1'b0, $urandom_range(1, 25));
      else if (r < 8) seg(1'b0, $urandom_range(26, 60));
      else            seg(1'b0, $urandom_range(61, 100));
      if ($urandom_range(0, 39) == 0) begin
        key = $urandom_range(0, 1);
        rst = 1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 0;
      end
    end
    seg(1'b0, 10 * U);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
